instr_fetch: RTL and testbench
==============================

// Module: instr_fetch
// PURPOSE
//  Fetch stage placed directly upstream of the program ROM; the ROM read is combinational.
//  - Holds the program counter and drives the ROM address.
//  - Registers each ROM word into a fetch output register (instruction + PC) and presents
//    it to decode over a valid/ready handshake.
//  - Supports redirect (jump/flush) and a halt after fetching an OUT instruction.
// PARAMETERS
//  ADDR_W       3    ROM address width; PC wraps modulo 2**ADDR_W
//  INSTR_W      32   instruction width
//  HALT_ON_OUT  1    1: stop fetching after an OUT (opcode 4'hF) is captured
// PORTS
//  clk             in   1        single clock, rising edge
//  rst             in   1        synchronous, active-high reset
//  en              in   1        fetch enable; 0 = stall (nothing captured, PC holds)
//  rom_addr        out  ADDR_W   ROM address; combinationally equal to pc
//  rom_instr       in   INSTR_W  ROM data for rom_addr, same cycle
//  redirect_valid  in   1        load a new PC and flush the output register
//  redirect_addr   in   ADDR_W   new PC
//  if_valid        out  1        fetch register holds an unconsumed instruction
//  if_instr        out  INSTR_W  captured instruction
//  if_pc           out  ADDR_W   address if_instr was fetched from
//  if_ready        in   1        decode accepts if_instr when if_valid && if_ready
//  halted          out  1        FSM is in HALT
// BEHAVIOUR
//  - Reset (rst=1 at an edge):
//    - pc=0, if_valid=0, if_instr=0, if_pc=0, halted=0, state=RUN.
//    - rst has priority over every other input.
//  - FSM: RUN, HALT. halted = (state == HALT).
//  - fire = state==RUN && en && !redirect_valid && (!if_valid || if_ready).
//    - On fire: if_instr<=rom_instr, if_pc<=pc, if_valid<=1, pc<=pc+1 (mod 2**ADDR_W).
//    - Address 7 wraps to 0.
//  - Consume without refill: if if_valid && if_ready && !fire, then if_valid<=0.
//  - Back-pressure: if if_valid && !if_ready, then if_instr, if_pc and pc all hold.
//    - if_instr and if_pc never change while valid and not accepted.
//  - Latency: first capture is at the first edge with en=1 after reset.
//    - Then 1 instruction/cycle with if_ready=1 held (full throughput, no bubbles).
//  - RUN->HALT: on a fire whose rom_instr[31:28]==4'hF, when HALT_ON_OUT=1.
//    - That OUT is still delivered (if_valid=1).
//    - pc is already incremented; no further fire.
//  - HALT->RUN: only on redirect_valid or rst.
//  - Redirect (any state, highest after rst):
//    - pc<=redirect_addr, if_valid<=0, state<=RUN; no capture that edge.
//    - Also overrides a simultaneous handshake: the held word is dropped.
//  - en=0 blocks fire only; the consume rule still clears if_valid.
// STRUCTURE
//  - fetch_pkg holds shared constants: OPC_HI=31, OPC_LO=28, OPC_NOP=4'h0,
//    OPC_ADDI=4'h1, OPC_ADD=4'h2, OPC_OUT=4'hF, and the FSM state enum {RUN,HALT}.
//    Decode reuses the same package.
//  - Single module; no sub-module. The ROM is instantiated beside it at the level above.
// TESTING  (bench instantiates ROM: [0]=1100000A [1]=1100000D [2]=21200000 [3..6]=0 [7]=F1000000)
//  1. Reset, then en=1, if_ready=1 ->
//     - if_instr: 1100000A, 1100000D, 21200000, 0, 0, 0, 0, F1000000 on consecutive cycles.
//     - if_pc = 0..7.
//     - After F1000000: halted=1, pc=0; if_valid falls the next cycle.
//  2. if_ready=0 for 3 cycles while if_instr=1100000D ->
//     - if_instr, if_pc=1 and rom_addr=2 stable.
//     - After if_ready=1, 21200000 follows with no loss or duplication.
//  3. redirect_valid=1, redirect_addr=7 while halted ->
//     - halted=0, if_valid=0 next cycle.
//     - Then F1000000 with if_pc=7; re-halts; pc=0.
//  4. HALT_ON_OUT=0 ->
//     - After F1000000 (pc 7), the next if_instr is 1100000A with if_pc=0 (wrap).
//  5. redirect together with if_valid && if_ready, addr=2 ->
//     - The held word is dropped; the next valid word is 21200000 with if_pc=2.
//  6. rst=1 mid-stream, with if_valid=1 and pc=5 ->
//     - Next cycle: if_valid=0, pc=0, halted=0, if_instr=0.
//  7. en=0 for 2 cycles mid-stream ->
//     - pc holds; the valid word is consumed, then if_valid=0.
//     - Resume restarts from the held pc.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch and decode stages: opcode field position,
// opcode values and the fetch FSM state encoding.
package fetch_pkg;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 28;

    localparam logic [3:0] OPC_NOP  = 4'h0;
    localparam logic [3:0] OPC_ADDI = 4'h1;
    localparam logic [3:0] OPC_ADD  = 4'h2;
    localparam logic [3:0] OPC_OUT  = 4'hF;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_e;

    // True when the instruction word carries the OUT opcode
    function automatic logic is_out(input logic [31:0] instr);
        return (instr[OPC_HI:OPC_LO] == OPC_OUT);
    endfunction

endpackage

// File: rtl/instr_fetch.sv
// Fetch stage in front of a combinational program ROM: owns the PC, registers
// each ROM word with its address and hands it to decode over valid/ready.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = 3,
    parameter int INSTR_W     = 32,
    parameter bit HALT_ON_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [INSTR_W-1:0] rom_instr,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_addr,
    output logic               if_valid,
    output logic [INSTR_W-1:0] if_instr,
    output logic [ADDR_W-1:0]  if_pc,
    input  logic               if_ready,
    output logic               halted
);

    fetch_state_e       state_r;
    fetch_state_e       state_s;
    logic [ADDR_W-1:0]  pc_r;
    logic [ADDR_W-1:0]  pc_s;
    logic               if_valid_r;
    logic               if_valid_s;
    logic [INSTR_W-1:0] if_instr_r;
    logic [INSTR_W-1:0] if_instr_s;
    logic [ADDR_W-1:0]  if_pc_r;
    logic [ADDR_W-1:0]  if_pc_s;
    logic               fire_s;
    logic [31:0]        opc_word_s;

    // Opcode inspection works on the top 32 bits regardless of INSTR_W
    always_comb begin
        opc_word_s = 32'h0000_0000;
        opc_word_s = 32'(rom_instr >> (INSTR_W - 32));
    end

    // Fire when running, enabled, not redirected and the output slot is free or draining
    always_comb begin
        fire_s = 1'b0;
        if ((state_r == RUN) && en && !redirect_valid && (!if_valid_r || if_ready)) begin
            fire_s = 1'b1;
        end else begin
            fire_s = 1'b0;
        end
    end

    // Next-state and next-datapath logic; redirect outranks capture and consume
    always_comb begin
        state_s    = state_r;
        pc_s       = pc_r;
        if_valid_s = if_valid_r;
        if_instr_s = if_instr_r;
        if_pc_s    = if_pc_r;
        if (redirect_valid) begin
            pc_s       = redirect_addr;
            if_valid_s = 1'b0;
            state_s    = RUN;
        end else if (fire_s) begin
            if_instr_s = rom_instr;
            if_pc_s    = pc_r;
            if_valid_s = 1'b1;
            pc_s       = pc_r + ADDR_W'(1);
            if (HALT_ON_OUT && is_out(opc_word_s)) begin
                state_s = HALT;
            end else begin
                state_s = state_r;
            end
        end else if (if_valid_r && if_ready) begin
            if_valid_s = 1'b0;
        end else begin
            if_valid_s = if_valid_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RUN;
        end else begin
            case (state_s)
                RUN:     state_r <= RUN;
                HALT:    state_r <= HALT;
                default: state_r <= RUN;
            endcase
        end
    end

    // PC and fetch output register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= {ADDR_W{1'b0}};
            if_valid_r <= 1'b0;
            if_instr_r <= {INSTR_W{1'b0}};
            if_pc_r    <= {ADDR_W{1'b0}};
        end else begin
            pc_r       <= pc_s;
            if_valid_r <= if_valid_s;
            if_instr_r <= if_instr_s;
            if_pc_r    <= if_pc_s;
        end
    end

    assign rom_addr = pc_r;
    assign if_valid = if_valid_r;
    assign if_instr = if_instr_r;
    assign if_pc    = if_pc_r;
    assign halted   = (state_r == HALT);

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: one instance halting on OUT, one that wraps
// past OUT, both fed from the same small program ROM.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        redirect_valid;
    logic [2:0]  redirect_addr;
    logic        if_ready;

    logic [2:0]  rom_addr0, rom_addr1;
    logic [31:0] rom_instr0, rom_instr1;
    logic        if_valid0, if_valid1;
    logic [31:0] if_instr0, if_instr1;
    logic [2:0]  if_pc0, if_pc1;
    logic        halted0, halted1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [2:0] a);
        case (a)
            3'd0:    return 32'h1100000A;
            3'd1:    return 32'h1100000D;
            3'd2:    return 32'h21200000;
            3'd7:    return 32'hF1000000;
            default: return 32'h00000000;
        endcase
    endfunction

    assign rom_instr0 = rom_f(rom_addr0);
    assign rom_instr1 = rom_f(rom_addr1);

    instr_fetch #(.ADDR_W(3), .INSTR_W(32), .HALT_ON_OUT(1'b1)) dut0 (
        .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr0), .rom_instr(rom_instr0),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .if_valid(if_valid0), .if_instr(if_instr0), .if_pc(if_pc0),
        .if_ready(if_ready), .halted(halted0)
    );

    instr_fetch #(.ADDR_W(3), .INSTR_W(32), .HALT_ON_OUT(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .rom_addr(rom_addr1), .rom_instr(rom_instr1),
        .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
        .if_valid(if_valid1), .if_instr(if_instr1), .if_pc(if_pc1),
        .if_ready(if_ready), .halted(halted1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_word(input string tag, input logic [31:0] instr, input logic [2:0] pc);
        check({tag, ".valid"}, 32'(if_valid0), 32'd1);
        check({tag, ".instr"}, if_instr0, instr);
        check({tag, ".pc"}, 32'(if_pc0), 32'(pc));
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_addr = 3'd0;
        step();
        check("rst.valid", 32'(if_valid0), 32'd0);
        check("rst.instr", if_instr0, 32'h0);
        check("rst.pc", 32'(if_pc0), 32'd0);
        check("rst.halted", 32'(halted0), 32'd0);
        check("rst.addr", 32'(rom_addr0), 32'd0);

        // 1: full-throughput stream to OUT, then halt
        rst = 1'b0; en = 1'b1; if_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check_word("t1.word", rom_f(3'(k)), 3'(k));
        end
        check("t1.halted", 32'(halted0), 32'd1);
        check("t1.pcwrap", 32'(rom_addr0), 32'd0);
        check("t4.nohalt", 32'(halted1), 32'd0);
        step();
        check("t1.drain", 32'(if_valid0), 32'd0);
        check("t1.stay", 32'(halted0), 32'd1);
        check("t1.nofire", 32'(rom_addr0), 32'd0);
        // 4: HALT_ON_OUT=0 wraps past OUT
        check("t4.valid", 32'(if_valid1), 32'd1);
        check("t4.instr", if_instr1, 32'h1100000A);
        check("t4.pc", 32'(if_pc1), 32'd0);

        // 3: redirect out of HALT to address 7
        redirect_valid = 1'b1; redirect_addr = 3'd7;
        step();
        check("t3.halted", 32'(halted0), 32'd0);
        check("t3.valid", 32'(if_valid0), 32'd0);
        check("t3.addr", 32'(rom_addr0), 32'd7);
        redirect_valid = 1'b0;
        step();
        check_word("t3.out", 32'hF1000000, 3'd7);
        check("t3.rehalt", 32'(halted0), 32'd1);
        check("t3.pc", 32'(rom_addr0), 32'd0);
        step();
        check("t3.drain", 32'(if_valid0), 32'd0);

        // 2: back-pressure while 1100000D is held
        redirect_valid = 1'b1; redirect_addr = 3'd0;
        step();
        redirect_valid = 1'b0;
        step();
        check_word("t2.w0", 32'h1100000A, 3'd0);
        step();
        check_word("t2.w1", 32'h1100000D, 3'd1);
        if_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check_word("t2.hold", 32'h1100000D, 3'd1);
            check("t2.addr", 32'(rom_addr0), 32'd2);
        end
        if_ready = 1'b1;
        step();
        check_word("t2.w2", 32'h21200000, 3'd2);
        step();
        check_word("t2.w3", 32'h00000000, 3'd3);

        // 5: redirect beats a simultaneous handshake
        redirect_valid = 1'b1; redirect_addr = 3'd2;
        step();
        check("t5.drop", 32'(if_valid0), 32'd0);
        check("t5.addr", 32'(rom_addr0), 32'd2);
        redirect_valid = 1'b0;
        step();
        check_word("t5.w2", 32'h21200000, 3'd2);

        // 6: reset mid-stream with pc=5, also outranking a redirect
        step();
        step();
        check_word("t6.pre", 32'h00000000, 3'd4);
        check("t6.pc5", 32'(rom_addr0), 32'd5);
        rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 3'd6;
        step();
        check("t6.valid", 32'(if_valid0), 32'd0);
        check("t6.addr", 32'(rom_addr0), 32'd0);
        check("t6.halted", 32'(halted0), 32'd0);
        check("t6.instr", if_instr0, 32'h0);
        rst = 1'b0; redirect_valid = 1'b0;

        // 7: en=0 stalls fetch but still lets the held word drain
        step();
        check_word("t7.w0", 32'h1100000A, 3'd0);
        step();
        check_word("t7.w1", 32'h1100000D, 3'd1);
        en = 1'b0;
        step();
        check("t7.consume", 32'(if_valid0), 32'd0);
        check("t7.hold1", 32'(rom_addr0), 32'd2);
        step();
        check("t7.idle", 32'(if_valid0), 32'd0);
        check("t7.hold2", 32'(rom_addr0), 32'd2);
        en = 1'b1;
        step();
        check_word("t7.resume", 32'h21200000, 3'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
